// File: rtl/fabric_ingress_gate.sv
// Ingress admission gate: forwards or drops whole AXI-Stream frames by destination port
// enable, truncates over-length frames, and keeps saturating frame/drop/truncation statistics.
module fabric_ingress_gate #(
   parameter int unsigned NUM_PORTS = 50,
   parameter int unsigned MAX_BEATS = 190,
   localparam int unsigned PORT_BITS = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic [NUM_PORTS-1:0] port_enable,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic [63:0]          s_tdata,
   input  logic [7:0]           s_tkeep,
   input  logic                 s_tlast,
   input  logic [PORT_BITS:0]   s_tdest,
   input  logic [11:0]          s_tuser,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [63:0]          m_tdata,
   output logic [7:0]           m_tkeep,
   output logic                 m_tlast,
   output logic [PORT_BITS:0]   m_tdest,
   output logic [11:0]          m_tuser,
   output logic [31:0]          frame_count,
   output logic [31:0]          drop_count,
   output logic [31:0]          trunc_count
);

   localparam int unsigned CNT_BITS = $clog2(MAX_BEATS + 1);
   localparam int unsigned EN_SPAN  = 1 << PORT_BITS;

   typedef enum logic [1:0] {StIdle, StForward, StDrop, StFlush} state_t;

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] beat_cnt_q;
   logic [CNT_BITS-1:0] beat_num;
   logic [PORT_BITS-1:0] port;
   logic [EN_SPAN-1:0]  en_pad;
   logic                admit, trunc, accept, first, load, drop_new;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Pad the enable vector so out-of-range port numbers index a zero bit.
   assign port     = s_tdest[PORT_BITS-1:0];
   assign en_pad   = EN_SPAN'(port_enable);
   assign admit    = s_tdest[PORT_BITS] | ((32'(port) < NUM_PORTS) & en_pad[port]);
   assign beat_num = (state_q == StIdle) ? CNT_BITS'(1) : beat_cnt_q + CNT_BITS'(1);
   assign trunc    = (beat_num == CNT_BITS'(MAX_BEATS)) && !s_tlast;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) state_q <= StIdle;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            StIdle: begin
               if (admit) state_d = trunc ? StFlush : (s_tlast ? StIdle : StForward);
               else       state_d = s_tlast ? StIdle : StDrop;
            end
            StForward: state_d = trunc ? StFlush : (s_tlast ? StIdle : StForward);
            StDrop, StFlush: begin
               if (s_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      s_tready = 1'b1;
      if (state_q == StIdle || state_q == StForward) s_tready = !m_tvalid || m_tready;
      accept   = s_tvalid && s_tready;
      first    = (state_q == StIdle);
      load     = accept && ((first && admit) || state_q == StForward);
      drop_new = accept && first && !admit;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tkeep     <= '0;
         m_tlast     <= 1'b0;
         m_tdest     <= '0;
         m_tuser     <= '0;
         beat_cnt_q  <= '0;
         frame_count <= '0;
         drop_count  <= '0;
         trunc_count <= '0;
      end else begin
         if (load) begin
            m_tvalid   <= 1'b1;
            m_tdata    <= s_tdata;
            m_tkeep    <= s_tkeep;
            m_tlast    <= s_tlast | trunc;
            beat_cnt_q <= beat_num;
            // Routing fields only move on a first beat; later beats reuse them.
            if (first) begin
               m_tdest <= s_tdest;
               m_tuser <= s_tuser;
            end
            if (s_tlast || trunc) frame_count <= sat_inc(frame_count);
            if (trunc)            trunc_count <= sat_inc(trunc_count);
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
         if (drop_new) drop_count <= sat_inc(drop_count);
      end
   end

endmodule
